// File: rtl/sigmoid_approx.sv
// Pipelined binary32 sigmoid: piecewise-linear fit evaluated on |x| in fixed point,
// then renormalised and rounded back to float. Three cycles from sampling edge to output.
module sigmoid_approx #(
  parameter int exp_width   = 8,
  parameter int mant_width  = 24,
  parameter int total_width = exp_width + mant_width
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic [total_width-1:0] in_x,
  input  logic [2:0]             round_mode,
  output logic [total_width-1:0] out_sigmoid,
  output logic [4:0]             exceptions
);
  localparam int frac_width = mant_width - 1;
  localparam int bias       = (1 << (exp_width - 1)) - 1;
  localparam int a_width    = 33;  // |x| as 3.30
  localparam int a_frac     = 30;
  localparam int y_width    = 36;  // 1.35: a/32 of a 3.30 value stays exact
  localparam int sum_width  = mant_width + 1;

  localparam logic [a_width-1:0] a_five   = a_width'(5) << a_frac;
  localparam logic [a_width-1:0] a_brk_hi = a_width'(19) << (a_frac - 3);  // 2.375
  localparam logic [a_width-1:0] a_one    = a_width'(1) << a_frac;
  localparam logic [y_width-1:0] y_one    = y_width'(1) << 35;
  localparam logic [y_width-1:0] y_c_hi   = y_width'(27) << 30;  // 0.84375
  localparam logic [y_width-1:0] y_c_mid  = y_width'(5) << 32;   // 0.625
  localparam logic [y_width-1:0] y_c_lo   = y_width'(1) << 34;   // 0.5
  localparam logic [total_width-1:0] qnan =
    {1'b0, {exp_width{1'b1}}, 1'b1, {(frac_width-1){1'b0}}};

  // Input capture; valid bits keep post-reset garbage from reaching the output.
  logic [total_width-1:0] x_reg;
  logic [2:0]             rm_reg;
  logic [2:0]             vld_reg;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      x_reg   <= '0;
      rm_reg  <= '0;
      vld_reg <= '0;
    end else begin
      x_reg   <= in_x;
      rm_reg  <= round_mode;
      vld_reg <= {vld_reg[1:0], 1'b1};
    end
  end

  // Stage 1: |x| to 3.30 fixed point with sticky
  logic                    sign_w;
  logic [exp_width-1:0]    e_w;
  logic [frac_width-1:0]   f_w;
  logic [a_width-1:0]      a_w;
  logic                    sticky_w;
  logic                    nan_w;
  logic [2*mant_width-1:0] ext_w;
  int                      ue;
  int                      sh;

  assign {sign_w, e_w, f_w} = x_reg;

  always_comb begin
    a_w      = '0;
    sticky_w = 1'b0;
    nan_w    = 1'b0;
    ext_w    = '0;
    ue       = int'(e_w) - bias;
    sh       = ue + a_frac - frac_width;
    if (&e_w) begin
      nan_w = |f_w;
      a_w   = a_five;  // infinities saturate like any large operand
    end else if (e_w == '0) begin
      sticky_w = |f_w;
    end else if (ue >= 3) begin
      a_w = a_five;
    end else if (sh >= 0) begin
      a_w = a_width'({1'b1, f_w}) << sh;
      if (a_w > a_five) a_w = a_five;
    end else begin
      ext_w    = {1'b1, f_w, {mant_width{1'b0}}} >> ((-sh > mant_width) ? mant_width : -sh);
      a_w      = a_width'(ext_w[2*mant_width-1:mant_width]);
      sticky_w = |ext_w[mant_width-1:0];
    end
  end

  logic [a_width-1:0] s1_a_reg;
  logic               s1_sticky_reg;
  logic               s1_sign_reg;
  logic               s1_nan_reg;
  logic [2:0]         s1_rm_reg;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      s1_a_reg      <= '0;
      s1_sticky_reg <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_nan_reg    <= 1'b0;
      s1_rm_reg     <= '0;
    end else begin
      s1_a_reg      <= a_w;
      s1_sticky_reg <= sticky_w;
      s1_sign_reg   <= sign_w;
      s1_nan_reg    <= nan_w;
      s1_rm_reg     <= rm_reg;
    end
  end

  // Stage 2: in 1.35, a/32 is the raw 3.30 word, so slopes become left shifts
  logic [y_width-1:0] y_w;
  logic [y_width-1:0] r_w;

  always_comb begin
    if (s1_a_reg >= a_five)        y_w = y_one;
    else if (s1_a_reg >= a_brk_hi) y_w = y_width'(s1_a_reg) + y_c_hi;
    else if (s1_a_reg >= a_one)    y_w = (y_width'(s1_a_reg) << 2) + y_c_mid;
    else                           y_w = (y_width'(s1_a_reg) << 3) + y_c_lo;
    r_w = s1_sign_reg ? (y_one - y_w) : y_w;
  end

  logic [y_width-1:0] s2_r_reg;
  logic               s2_sticky_reg;
  logic               s2_nan_reg;
  logic [2:0]         s2_rm_reg;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      s2_r_reg      <= '0;
      s2_sticky_reg <= 1'b0;
      s2_nan_reg    <= 1'b0;
      s2_rm_reg     <= '0;
    end else begin
      s2_r_reg      <= r_w;
      s2_sticky_reg <= s1_sticky_reg;
      s2_nan_reg    <= s1_nan_reg;
      s2_rm_reg     <= s1_rm_reg;
    end
  end

  // Stage 3: normalise, round, pack (result is never negative, so RDN acts as RTZ)
  int                     lead;
  logic [y_width-1:0]     norm_w;
  logic [mant_width-1:0]  sig_w;
  logic                   guard_w;
  logic                   rest_w;
  logic                   up_w;
  logic [sum_width-1:0]   sum_w;
  logic [exp_width-1:0]   exp_w;
  logic [frac_width-1:0]  frac_w;
  logic [total_width-1:0] res_w;
  logic                   inexact_w;

  always_comb begin
    lead = 0;
    for (int i = 0; i < y_width; i++) begin
      if (s2_r_reg[i]) lead = i;
    end
    norm_w  = s2_r_reg << (y_width - 1 - lead);
    sig_w   = norm_w[y_width-1 -: mant_width];
    guard_w = norm_w[y_width-1-mant_width];
    rest_w  = (|norm_w[y_width-2-mant_width:0]) | s2_sticky_reg;
    case (s2_rm_reg)
      3'b001, 3'b010: up_w = 1'b0;
      3'b011:         up_w = guard_w | rest_w;
      3'b100:         up_w = guard_w;
      default:        up_w = guard_w & (rest_w | sig_w[0]);
    endcase
    sum_w     = {1'b0, sig_w} + sum_width'(up_w);
    exp_w     = exp_width'(bias - (y_width - 1) + lead + int'(sum_w[mant_width]));
    frac_w    = sum_w[mant_width] ? sum_w[mant_width-1:1] : sum_w[frac_width-1:0];
    res_w     = {1'b0, exp_w, frac_w};
    inexact_w = guard_w | rest_w;
    if (s2_nan_reg) begin
      res_w     = qnan;
      inexact_w = 1'b0;
    end else if (s2_r_reg == '0) begin
      res_w     = '0;
      inexact_w = s2_sticky_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      out_sigmoid <= '0;
      exceptions  <= '0;
    end else if (vld_reg[2]) begin
      out_sigmoid <= res_w;
      exceptions  <= {s2_nan_reg, 3'b000, inexact_w};
    end
  end
endmodule

// File: tb/tb_sigmoid_approx.sv
// Scoreboard bench for sigmoid_approx: driver queues hand-computed results,
// monitor pops and compares three cycles after each issued operand.
module tb_sigmoid_approx;
  logic        clk = 1'b0;
  logic        rst_l;
  logic [31:0] in_x;
  logic [2:0]  round_mode;
  logic [31:0] out_sigmoid;
  logic [4:0]  exceptions;

  always #5 clk = ~clk;

  sigmoid_approx dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .in_x       (in_x),
    .round_mode (round_mode),
    .out_sigmoid(out_sigmoid),
    .exceptions (exceptions)
  );

  typedef struct packed {
    logic [31:0] x;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  exc;
  } txn_t;

  // Idle operand is -inf, whose sigmoid is +0.0 with no flags, same as the reset value.
  localparam logic [31:0] idle_x = 32'hFF800000;

  txn_t       exp_q[$];
  txn_t       mon_t;
  int         total = 0;
  int         bad = 0;
  logic       iss = 1'b0;
  logic [3:0] vpipe = 4'b0;
  logic       armed = 1'b0;

  task automatic issue(input logic [31:0] x, input logic [2:0] rm,
                       input logic [31:0] res, input logic [4:0] exc);
    txn_t t;
    @(negedge clk);
    in_x = x;
    round_mode = rm;
    iss = 1'b1;
    t.x = x; t.rm = rm; t.res = res; t.exc = exc;
    exp_q.push_back(t);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_x = idle_x;
      round_mode = 3'b000;
      iss = 1'b0;
    end
  endtask

  // Latency tracker: reset discards everything in flight
  always @(posedge clk) begin
    if (!rst_l) begin
      vpipe <= 4'b0;
      exp_q.delete();
      armed <= 1'b1;
    end else begin
      vpipe <= {vpipe[2:0], iss};
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      total++;
      if (vpipe[3]) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty: got out=%h exc=%b, required a queued entry", out_sigmoid, exceptions);
        end else begin
          mon_t = exp_q.pop_front();
          if (out_sigmoid !== mon_t.res || exceptions !== mon_t.exc) begin
            bad++;
            $display("FAIL txn x=%h rm=%0d: got out=%h exc=%b, required out=%h exc=%b",
                     mon_t.x, mon_t.rm, out_sigmoid, exceptions, mon_t.res, mon_t.exc);
          end else begin
            $display("txn x=%h rm=%0d out=%h exc=%b ok", mon_t.x, mon_t.rm, out_sigmoid, exceptions);
          end
        end
      end else if (out_sigmoid !== 32'h0 || exceptions !== 5'h0) begin
        bad++;
        $display("FAIL idle_zero: got out=%h exc=%b, required out=00000000 exc=00000", out_sigmoid, exceptions);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sx[11];
    logic [31:0] sy[11];
    sx = '{32'hC0A00000, 32'hC0800000, 32'hC0400000, 32'hC0000000, 32'hBF800000, 32'h00000000,
           32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    sy = '{32'h00000000, 32'h3D000000, 32'h3D800000, 32'h3E000000, 32'h3E800000, 32'h3F000000,
           32'h3F400000, 32'h3F600000, 32'h3F700000, 32'h3F780000, 32'h3F800000};

    rst_l = 1'b0;
    in_x = idle_x;
    round_mode = 3'b000;
    @(negedge clk);
    rst_l = 1'b1;
    idle(5);

    // Sweep, each value held for three cycles
    for (int i = 0; i < 11; i++) begin
      repeat (3) issue(sx[i], 3'b000, sy[i], 5'b00000);
    end
    idle(4);

    // Saturation, specials and zero/subnormal inputs
    issue(32'h42C80000, 3'b000, 32'h3F800000, 5'b00000);
    issue(32'h7F800000, 3'b000, 32'h3F800000, 5'b00000);
    issue(32'hFF800000, 3'b000, 32'h00000000, 5'b00000);
    issue(32'h7FC00001, 3'b000, 32'h7FC00000, 5'b10000);
    issue(32'hFFC00000, 3'b000, 32'h7FC00000, 5'b10000);
    issue(32'h80000000, 3'b000, 32'h3F000000, 5'b00000);
    issue(32'h00000001, 3'b000, 32'h3F000000, 5'b00001);
    issue(32'h80000001, 3'b000, 32'h3F000000, 5'b00001);

    // Segment boundaries
    issue(32'h40180000, 3'b000, 32'h3F6B0000, 5'b00000);
    issue(32'h40100000, 3'b000, 32'h3F680000, 5'b00000);
    issue(32'h3F000000, 3'b000, 32'h3F200000, 5'b00000);
    issue(32'hBF000000, 3'b000, 32'h3EC00000, 5'b00000);
    idle(4);

    // Back-to-back throughput
    issue(32'h3F800000, 3'b000, 32'h3F400000, 5'b00000);
    issue(32'h40000000, 3'b000, 32'h3F600000, 5'b00000);
    issue(32'h00000000, 3'b000, 32'h3F000000, 5'b00000);
    idle(4);

    // Rounding of 0.1 under every mode (101 behaves as RNE)
    issue(32'h3DCCCCCD, 3'b000, 32'h3F066666, 5'b00001);
    issue(32'h3DCCCCCD, 3'b001, 32'h3F066666, 5'b00001);
    issue(32'h3DCCCCCD, 3'b010, 32'h3F066666, 5'b00001);
    issue(32'h3DCCCCCD, 3'b011, 32'h3F066667, 5'b00001);
    issue(32'h3DCCCCCD, 3'b100, 32'h3F066666, 5'b00001);
    issue(32'h3DCCCCCD, 3'b101, 32'h3F066666, 5'b00001);

    // Exact half-ulp tie at 0.5 + 2^-25, and just above it
    issue(32'h34000000, 3'b000, 32'h3F000000, 5'b00001);
    issue(32'h34000000, 3'b100, 32'h3F000001, 5'b00001);
    issue(32'h34000000, 3'b011, 32'h3F000001, 5'b00001);
    issue(32'h34000000, 3'b001, 32'h3F000000, 5'b00001);
    issue(32'h34400000, 3'b000, 32'h3F000001, 5'b00001);
    idle(4);

    // Reset one cycle after an operand: its result must never appear
    issue(32'h3F800000, 3'b000, 32'h3F400000, 5'b00000);
    @(negedge clk);
    rst_l = 1'b0;
    in_x = idle_x;
    iss = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    idle(6);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
